// File: rtl/aes_edn_arbiter_pkg.sv
// rtl/aes_edn_arbiter_pkg.sv - shared types and constants for the EDN entropy arbiter
package aes_edn_arbiter_pkg;

  // One-hot state codes so a single flipped bit is detectable as an illegal state.
  typedef enum logic [2:0] {
    ARB_IDLE    = 3'b001,
    ARB_BUSY    = 3'b010,
    ARB_DISCARD = 3'b100
  } aes_edn_arb_e;

  localparam int unsigned EdnArbTimeoutDefault = 1024;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_edn_arbiter_if.sv
// rtl/aes_edn_arbiter_if.sv - requester and EDN synchronizer handshake bundle
interface aes_edn_arbiter_if #(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned EntropyWidth = 32
) ();

  logic [NumReq-1:0]       req_i;
  logic [NumReq-1:0]       ack_o;
  logic [EntropyWidth-1:0] data_o;
  logic                    edn_req_o;
  logic                    edn_ack_i;
  logic [EntropyWidth-1:0] edn_data_i;

  modport slave (
    input  req_i, edn_ack_i, edn_data_i,
    output ack_o, data_o, edn_req_o
  );

  modport master (
    output req_i, edn_ack_i, edn_data_i,
    input  ack_o, data_o, edn_req_o
  );

endinterface

// File: rtl/aes_edn_arb_sel.sv
// rtl/aes_edn_arb_sel.sv - combinational winner picker, round-robin from ptr or lowest index
module aes_edn_arb_sel #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  input  logic              rr_mode,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx
);

  localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NumReq);

  always_comb begin
    logic          found;
    logic [IdxW:0] base;
    logic [IdxW:0] cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Fixed priority is just a round-robin scan that always starts at 0.
    base  = rr_mode ? {1'b0, ptr} : '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = base + (IdxW+1)'(i);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!found && req[cand[IdxW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[IdxW-1:0]]  = 1'b1;
        idx                  = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/aes_edn_arbiter.sv
// rtl/aes_edn_arbiter.sv - grant-locked arbiter sharing one EDN req/ack port among consumers,
// with a sticky stall watchdog
module aes_edn_arbiter
  import aes_edn_arbiter_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned EntropyWidth  = 32,
  parameter bit          RoundRobin    = 1'b1,
  parameter int unsigned TimeoutCycles = EdnArbTimeoutDefault,
  localparam int unsigned IdxW         = idx_width(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  aes_edn_arbiter_if.slave    edn_if,
  output logic [IdxW-1:0]     gnt_idx_o,
  output logic                busy_o,
  output logic                timeout_err_o,
  input  logic                clear_err_i
);

  localparam int unsigned   CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
  localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NumReq);

  aes_edn_arb_e      state_q;
  logic              edn_req_q;
  logic [IdxW-1:0]   gnt_q;
  logic [IdxW-1:0]   ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              err_q;

  logic [NumReq-1:0] sel_gnt;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW:0]     gnt_plus;
  logic [IdxW-1:0]   ptr_inc;
  logic [CntW-1:0]   cnt_inc;
  logic              active;
  logic              req_gnt;
  logic              wd_set;

  aes_edn_arb_sel #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_sel (
    .req     (edn_if.req_i),
    .ptr     (ptr_q),
    .rr_mode (RoundRobin),
    .gnt     (sel_gnt),
    .idx     (sel_idx)
  );

  assign active   = (state_q != ARB_IDLE);
  assign req_gnt  = edn_if.req_i[gnt_q];
  assign gnt_plus = {1'b0, gnt_q} + 1'b1;
  assign ptr_inc  = (gnt_plus >= NumReqW) ? '0 : gnt_plus[IdxW-1:0];
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  // Flag on the edge the counter reaches the limit; keeps re-asserting while saturated.
  assign wd_set   = (TimeoutCycles != 0) && active && !edn_if.edn_ack_i && (cnt_inc == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      edn_req_q <= 1'b0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (|edn_if.req_i) begin
            state_q   <= ARB_BUSY;
            gnt_q     <= sel_idx;
            edn_req_q <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (edn_if.edn_ack_i) begin
            state_q   <= ARB_IDLE;
            edn_req_q <= 1'b0;
            ptr_q     <= ptr_inc;
          end else if (!req_gnt) begin
            // The synchronizer cannot take a request back, so ride it out.
            state_q   <= ARB_DISCARD;
          end
        end
        ARB_DISCARD: begin
          if (edn_if.edn_ack_i) begin
            state_q   <= ARB_IDLE;
            edn_req_q <= 1'b0;
            ptr_q     <= ptr_inc;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          edn_req_q <= 1'b0;
        end
      endcase

      if (!active || edn_if.edn_ack_i) cnt_q <= '0;
      else                             cnt_q <= cnt_inc;

      if (wd_set)           err_q <= 1'b1;
      else if (clear_err_i) err_q <= 1'b0;
    end
  end

  always_comb begin
    edn_if.ack_o = '0;
    if (state_q == ARB_BUSY && edn_if.edn_ack_i && req_gnt) edn_if.ack_o[gnt_q] = 1'b1;
  end

  assign edn_if.data_o    = edn_if.edn_ack_i ? edn_if.edn_data_i : '0;
  assign edn_if.edn_req_o = edn_req_q;
  assign gnt_idx_o        = gnt_q;
  assign busy_o           = active;
  assign timeout_err_o    = err_q;

  a_ack_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(edn_if.ack_o));
  a_ack_edn: assert property (@(posedge clk_i) disable iff (rst_i)
    (|edn_if.ack_o) |-> edn_if.edn_ack_i);
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (edn_req_q && !edn_if.edn_ack_i) |=> edn_req_q);
  a_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({edn_if.ack_o, edn_if.data_o, edn_req_q, gnt_q, active, err_q}));
  a_idle_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ARB_IDLE) |-> !edn_if.edn_ack_i);
  a_sel_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(sel_gnt));

endmodule

// File: doc/aes_edn_arbiter.md
Name: aes_edn_arbiter

Overview:
- Shares the single EDN entropy request/ack interface between NumReq internal entropy consumers (clearing PRNG, masking PRNG, future key-sideload PRNG).
- Sits between the aes_core entropy ports and the EDN clock-domain req/ack synchronizer.
- Replaces the combinational OR/priority scheme with a registered, grant-locked round-robin or fixed-priority arbiter.
- Provides a stall watchdog for alert generation.

Parameters:
- NumReq, 2, number of entropy requesters (2..8); index 0 is highest priority in fixed mode.
- EntropyWidth, 32, width of the EDN data bus.
- RoundRobin, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- TimeoutCycles, 1024, number of cycles in BUSY before timeout_err_o is set; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NumReq  per-requester entropy request, level, held until ack.
- ack_o  out  NumReq  per-requester ack, single-cycle pulse, one-hot or zero.
- data_o  out  EntropyWidth  entropy to requesters, broadcast, valid only while some ack_o bit is set.
- edn_req_o  out  1  request to the EDN synchronizer, registered.
- edn_ack_i  in  1  ack from the EDN synchronizer, single-cycle.
- edn_data_i  in  EntropyWidth  EDN data, valid with edn_ack_i.
- gnt_idx_o  out  $clog2(NumReq) (min 1)  index of the current or last granted requester.
- busy_o  out  1  high while in BUSY or DISCARD.
- timeout_err_o  out  1  sticky watchdog flag.
- clear_err_i  in  1  clears timeout_err_o.

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; edn_req_o=0; ack_o=0; gnt_idx_o=0; RR pointer=0; watchdog counter=0; timeout_err_o=0; busy_o=0. A reset mid-handshake abandons the transaction with no ack_o.
- State IDLE:
  - If any req_i bit is set, select a winner, register it into gnt_idx, and move to BUSY.
  - edn_req_o goes high in the cycle after req_i is seen (1-cycle latency).
- Winner selection:
  - RoundRobin=1: first set bit searching upward from ptr, wrapping modulo NumReq.
  - RoundRobin=0: lowest set index.
- State BUSY:
  - edn_req_o=1. The grant is locked; new or higher-priority requests are ignored.
  - On edn_ack_i with req_i[gnt_idx]=1: ack_o[gnt_idx]=1 and data_o=edn_data_i, combinationally in the same cycle. Go to IDLE. RR ptr becomes (gnt_idx+1) mod NumReq.
  - If req_i[gnt_idx] drops before ack: go to DISCARD. edn_req_o stays high, because the synchronizer protocol forbids withdrawal.
- State DISCARD:
  - edn_req_o=1. On edn_ack_i the data is dropped, ack_o stays 0, RR ptr advances as in BUSY, and the state returns to IDLE.
- edn_req_o is low for at least one cycle between consecutive transactions (IDLE is always visited).
- Simultaneous requests: exactly one grant per transaction. A loser keeps req_i high and is served in a later transaction.
- ack_o is never asserted without edn_ack_i in the same cycle. ack_o is never multi-hot.
- data_o = edn_data_i whenever edn_ack_i is high, otherwise 0. No X propagates out.
- Watchdog:
  - Counter increments each cycle in BUSY or DISCARD and clears on entering IDLE.
  - Saturates at TimeoutCycles. When count == TimeoutCycles, timeout_err_o is set.
  - The flag stays set until clear_err_i=1. If a set and a clear coincide, set wins.
  - The transaction is not aborted on timeout.
- edn_ack_i arriving in IDLE is ignored (protocol error, flagged by assertion only).

Decomposition:
- aes_pkg additions:
  - Enum aes_edn_arb_e {ARB_IDLE, ARB_BUSY, ARB_DISCARD}, sparse encoding.
  - Constant EdnArbTimeoutDefault = 1024.
- Sub-module aes_edn_arb_sel: purely combinational winner picker (req vector, ptr, mode -> one-hot grant + index).
- FSM, pointer and watchdog stay in the top module.
- Assertions:
  - ack_o is onehot0.
  - ack_o implies edn_ack_i.
  - edn_req_o stable until edn_ack_i.
  - Outputs known after reset.

Test Plan:
- Single request: req_i=2'b01 at cycle 0, edn_ack_i at cycle 4 with data 0xDEADBEEF -> edn_req_o high cycles 1-4; ack_o=2'b01 and data_o=0xDEADBEEF at cycle 4; IDLE at cycle 5.
- Round-robin contention: req_i=2'b11 held, 4 transactions -> ack_o order 01,10,01,10; edn_req_o low for 1 cycle between each transaction.
- Fixed priority (RoundRobin=0): req_i=2'b11 held for 3 transactions -> ack_o always 01; requester 1 is served only after req_i[0] drops.
- Withdrawal: grant requester 1, drop req_i[1] before edn_ack_i -> DISCARD; edn_req_o held; ack with 0x12345678 produces ack_o=0; next grant goes to requester 0.
- Watchdog: TimeoutCycles=8, withhold edn_ack_i -> timeout_err_o rises exactly 8 cycles after BUSY entry; a later ack completes normally; the flag persists until clear_err_i.
- Reset mid-BUSY: rst_i=1 while edn_req_o=1 -> next cycle edn_req_o=0, state IDLE, ptr=0, no ack_o.
